comparador_serial: RTL

COMPARADOR_SERIAL -- requirements
Module: comparador_serial

---
 rtl/comparador_pkg.sv | 5 +
 rtl/celda_comparador.sv | 11 +
 rtl/comparador_serial.sv | 63 ++++++
 3 files changed

// File: rtl/comparador_pkg.sv
// comparador_pkg: shared state and result encodings for the serial comparator
package comparador_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
    typedef enum logic [1:0] {EQ = 2'b00, GT = 2'b01, LT = 2'b10} res_t;
endpackage

// File: rtl/celda_comparador.sv
// celda_comparador: per-bit update of the running comparison result
module celda_comparador
    import comparador_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  res_t res,
    output res_t res_n
);
    assign res_n = (a_i & ~b_i) ? GT : (~a_i & b_i) ? LT : res;
endmodule

// File: rtl/comparador_serial.sv
// comparador_serial: LSB-first bit-serial unsigned magnitude comparator
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] wordA,
    input  logic [N-1:0] wordB,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);
    localparam int CW = $clog2(N);
    state_t        state, state_n;
    res_t          res, res_n;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sa, sb;
    logic          load, last;
    assign last = cnt == CW'(N - 1);
    assign busy = state == SHIFT;
    assign done = state == DONE;
    celda_comparador u_celda (.a_i(sa[0]), .b_i(sb[0]), .res(res), .res_n(res_n));
    always_comb begin
        load    = (state != SHIFT) && start;
        state_n = load ? SHIFT : (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    // Outputs only move on the edge that enters DONE, so they hold through IDLE and SHIFT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            res <= EQ;
            gt  <= 1'b0;
            eq  <= 1'b1;
            lt  <= 1'b0;
        end else if (load) begin
            sa  <= wordA;
            sb  <= wordB;
            cnt <= '0;
            res <= EQ;
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= res_n;
            cnt <= last ? cnt : cnt + 1'b1;
            if (last) begin
                gt <= res_n == GT;
                eq <= res_n == EQ;
                lt <= res_n == LT;
            end
        end
    end
endmodule
